// File: rtl/mandelbrot_pixel_scheduler.sv
// Raster-order pixel scheduler feeding mandelbrotCore and streaming results downstream.
// Optional inside-pixel counter enabled with `define MANDEL_SCHED_INSIDE_CNT_EN.
module mandelbrot_pixel_scheduler #(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
  parameter int COORD_WIDTH     = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          frame_start_i,
  input  logic [COORD_WIDTH-1:0]        width_i,
  input  logic [COORD_WIDTH-1:0]        height_i,
  input  logic signed [DATA_WIDTH-1:0]  x_min_i,
  input  logic signed [DATA_WIDTH-1:0]  y_max_i,
  input  logic signed [DATA_WIDTH-1:0]  step_i,
  input  logic [MAX_ITER_WIDTH-1:0]     max_iter_i,
  output logic                          core_start_o,
  output logic signed [DATA_WIDTH-1:0]  core_x0_o,
  output logic signed [DATA_WIDTH-1:0]  core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0]     core_max_iter_o,
  input  logic [MAX_ITER_WIDTH-1:0]     core_iter_i,
  input  logic                          core_done_i,
  output logic                          pix_valid_o,
  input  logic                          pix_ready_i,
  output logic [MAX_ITER_WIDTH-1:0]     pix_iter_o,
  output logic [COORD_WIDTH-1:0]        pix_col_o,
  output logic [COORD_WIDTH-1:0]        pix_row_o,
  output logic                          pix_eol_o,
  output logic                          pix_last_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic [2*COORD_WIDTH-1:0]      inside_count_o,
  output logic [2:0]                    state_o
);

  // Handshake: a pixel transfers on a rising clk_i edge where pix_valid_o && pix_ready_i;
  // once pix_valid_o rises, it and all pix_* payload stay fixed until that transfer.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    EMIT      = 3'd4
  } state_t;

  localparam logic [COORD_WIDTH-1:0] ONE_C = {{(COORD_WIDTH-1){1'b0}}, 1'b1};

  state_t                        state_q;
  logic [COORD_WIDTH-1:0]        width_q;
  logic [COORD_WIDTH-1:0]        height_q;
  logic signed [DATA_WIDTH-1:0]  x_min_q;
  logic signed [DATA_WIDTH-1:0]  step_q;
  logic signed [DATA_WIDTH-1:0]  x_q;
  logic signed [DATA_WIDTH-1:0]  y_q;
  logic [COORD_WIDTH-1:0]        col_q;
  logic [COORD_WIDTH-1:0]        row_q;
  logic                          last_col;
  logic                          last_row;
  logic                          accept;
  logic                          handshake;

  assign last_col  = (col_q == width_q - ONE_C);
  assign last_row  = (row_q == height_q - ONE_C);
  assign accept    = (state_q == IDLE) && frame_start_i;
  assign handshake = (state_q == EMIT) && pix_ready_i;
  assign busy_o    = (state_q != IDLE);
  assign state_o   = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      width_q         <= '0;
      height_q        <= '0;
      x_min_q         <= '0;
      step_q          <= '0;
      x_q             <= '0;
      y_q             <= '0;
      col_q           <= '0;
      row_q           <= '0;
      core_start_o    <= 1'b0;
      core_x0_o       <= '0;
      core_y0_o       <= '0;
      core_max_iter_o <= '0;
      pix_valid_o     <= 1'b0;
      pix_iter_o      <= '0;
      pix_col_o       <= '0;
      pix_row_o       <= '0;
      pix_eol_o       <= 1'b0;
      pix_last_o      <= 1'b0;
      frame_done_o    <= 1'b0;
    end else begin
      core_start_o <= 1'b0;
      frame_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            if (width_i == '0 || height_i == '0) begin
              frame_done_o <= 1'b1;
            end else begin
              width_q         <= width_i;
              height_q        <= height_i;
              x_min_q         <= x_min_i;
              step_q          <= step_i;
              x_q             <= x_min_i;
              y_q             <= y_max_i;
              col_q           <= '0;
              row_q           <= '0;
              core_max_iter_o <= max_iter_i;
              core_x0_o       <= x_min_i;
              core_y0_o       <= y_max_i;
              core_start_o    <= 1'b1;
              state_q         <= ISSUE;
            end
          end
        end
        ISSUE:    state_q <= WAIT_CLR;
        WAIT_CLR: state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (core_done_i) begin
            pix_iter_o  <= core_iter_i;
            pix_col_o   <= col_q;
            pix_row_o   <= row_q;
            pix_eol_o   <= last_col;
            pix_last_o  <= last_col && last_row;
            pix_valid_o <= 1'b1;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          if (pix_ready_i) begin
            pix_valid_o <= 1'b0;
            if (pix_last_o) begin
              frame_done_o <= 1'b1;
              state_q      <= IDLE;
            end else if (pix_eol_o) begin
              // Row wrap: real part restarts, imaginary part steps down one row.
              col_q        <= '0;
              row_q        <= row_q + ONE_C;
              x_q          <= x_min_q;
              y_q          <= y_q - step_q;
              core_x0_o    <= x_min_q;
              core_y0_o    <= y_q - step_q;
              core_start_o <= 1'b1;
              state_q      <= ISSUE;
            end else begin
              col_q        <= col_q + ONE_C;
              x_q          <= x_q + step_q;
              core_x0_o    <= x_q + step_q;
              core_y0_o    <= y_q;
              core_start_o <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MANDEL_SCHED_INSIDE_CNT_EN
  localparam logic [2*COORD_WIDTH-1:0] ONE_I = {{(2*COORD_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inside_count_o <= '0;
    end else if (accept) begin
      inside_count_o <= '0;
    end else if (handshake && (pix_iter_o == core_max_iter_o)) begin
      inside_count_o <= inside_count_o + ONE_I;
    end
  end
`else
  assign inside_count_o = '0;
`endif

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Directed bench for mandelbrot_pixel_scheduler with a behavioural core and a pixel scoreboard.
module tb_mandelbrot_pixel_scheduler;
  localparam int MW = 16;
  localparam int DW = 32;
  localparam int CW = 12;

  localparam logic signed [DW-1:0] XMIN = -32'sd33554432; // -2.0
  localparam logic signed [DW-1:0] YMAX = 32'sd16777216;  //  1.0
  localparam logic signed [DW-1:0] STEP = 32'sd8388608;   //  0.5

  logic clk_i = 1'b0;
  logic rst_i;
  logic frame_start_i;
  logic [CW-1:0] width_i, height_i;
  logic signed [DW-1:0] x_min_i, y_max_i, step_i;
  logic [MW-1:0] max_iter_i;
  logic core_start_o;
  logic signed [DW-1:0] core_x0_o, core_y0_o;
  logic [MW-1:0] core_max_iter_o;
  logic [MW-1:0] core_iter_i;
  logic core_done_i;
  logic pix_valid_o, pix_ready_i;
  logic [MW-1:0] pix_iter_o;
  logic [CW-1:0] pix_col_o, pix_row_o;
  logic pix_eol_o, pix_last_o, busy_o, frame_done_o;
  logic [2*CW-1:0] inside_count_o;
  logic [2:0] state_o;

  mandelbrot_pixel_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start_i),
    .width_i(width_i), .height_i(height_i),
    .x_min_i(x_min_i), .y_max_i(y_max_i), .step_i(step_i), .max_iter_i(max_iter_i),
    .core_start_o(core_start_o), .core_x0_o(core_x0_o), .core_y0_o(core_y0_o),
    .core_max_iter_o(core_max_iter_o), .core_iter_i(core_iter_i), .core_done_i(core_done_i),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_iter_o(pix_iter_o),
    .pix_col_o(pix_col_o), .pix_row_o(pix_row_o), .pix_eol_o(pix_eol_o),
    .pix_last_o(pix_last_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .inside_count_o(inside_count_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // behavioural core: done rises 11 edges after the start edge, iteration from res_q or default
  logic [MW-1:0] res_q[$];
  logic [MW-1:0] default_iter = 16'd7;
  int core_cnt;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_done_i <= 1'b0;
      core_iter_i <= '0;
      core_cnt    <= 0;
    end else if (core_start_o) begin
      core_done_i <= 1'b0;
      core_cnt    <= 11;
      if (res_q.size() != 0) core_iter_i <= res_q.pop_front();
      else core_iter_i <= default_iter;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_done_i <= 1'b1;
    end
  end

  // scoreboard: {col,row,eol,last,iter} and {x0,y0}
  logic [41:0] exp_q[$];
  logic [63:0] exp_coord_q[$];
  logic [MW-1:0] exp_max_iter;

  int cyc = 0;
  int start_cnt = 0, done_cnt = 0, start_wide = 0, period_bad = 0, stall_starts = 0;
  int last_start_cyc = -1;
  bit period_en = 0, stalling = 0, prev_start = 0;
  logic signed [DW-1:0] last_x0, last_y0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (core_start_o) begin
        start_cnt++;
        if (prev_start) start_wide++;
        if (period_en && last_start_cyc >= 0 && (cyc - last_start_cyc) != 14) period_bad++;
        last_start_cyc = cyc;
        last_x0 = core_x0_o;
        last_y0 = core_y0_o;
        if (stalling) stall_starts++;
        check("start_expected", 64'(exp_coord_q.size() == 0), 64'd0);
        if (exp_coord_q.size() != 0) check("core_xy", {core_x0_o, core_y0_o}, exp_coord_q.pop_front());
        check("core_max_iter", 64'(core_max_iter_o), 64'(exp_max_iter));
      end
      prev_start = core_start_o;
      if (frame_done_o) done_cnt++;
      if (pix_valid_o && pix_ready_i) begin
        check("pix_expected", 64'(exp_q.size() == 0), 64'd0);
        if (exp_q.size() != 0)
          check("pix", 64'({pix_col_o, pix_row_o, pix_eol_o, pix_last_o, pix_iter_o}), 64'(exp_q.pop_front()));
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  // driver tasks
  task automatic push_frame(input int w, input int h, input logic [MW-1:0] it);
    logic signed [DW-1:0] x, y;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x = XMIN + STEP * c;
        y = YMAX - STEP * r;
        exp_coord_q.push_back({x, y});
        exp_q.push_back({CW'(c), CW'(r), (c == w - 1), (c == w - 1) && (r == h - 1), it});
      end
    end
  endtask

  task automatic start_frame(input int w, input int h, input logic [MW-1:0] mi);
    width_i       = CW'(w);
    height_i      = CW'(h);
    x_min_i       = XMIN;
    y_max_i       = YMAX;
    step_i        = STEP;
    max_iter_i    = mi;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    for (int i = 0; i < limit && done_cnt == d0; i++) tick();
    check("frame_done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic wait_starts(input int target, input int limit);
    for (int i = 0; i < limit && start_cnt < target; i++) tick();
    check("start_reached", 64'(start_cnt >= target), 64'd1);
  endtask

  int s0, d0, stall_bad, busy_seen;
  logic [41:0] snap;

  initial begin
    rst_i = 1'b1; frame_start_i = 1'b0; pix_ready_i = 1'b1;
    width_i = '0; height_i = '0; x_min_i = '0; y_max_i = '0; step_i = '0; max_iter_i = '0;
    exp_max_iter = 16'd100;
    repeat (3) tick();
    check("rst_ctrl", 64'({core_start_o, pix_valid_o, busy_o, frame_done_o, pix_eol_o, pix_last_o}), 64'd0);
    check("rst_core_xy", {core_x0_o, core_y0_o}, 64'd0);
    check("rst_pix", 64'({pix_iter_o, pix_col_o, pix_row_o}), 64'd0);
    check("rst_max_iter", 64'(core_max_iter_o), 64'd0);
    check("rst_inside", 64'(inside_count_o), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // 4x3 frame, ready held high
    push_frame(4, 3, 16'd7);
    period_en = 1; last_start_cyc = -1;
    s0 = start_cnt; d0 = done_cnt;
    start_frame(4, 3, 16'd100);
    @(negedge clk_i);
    check("accept_to_start", 64'(core_start_o), 64'd1);
    check("busy_in_frame", 64'(busy_o), 64'd1);
    wait_done(d0, 400);
    repeat (5) tick();
    period_en = 0;
    check("f1_starts", 64'(start_cnt - s0), 64'd12);
    check("f1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("f1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("f1_period_14", 64'(period_bad), 64'd0);
    check("start_one_cycle", 64'(start_wide), 64'd0);
    check("last_x0", 64'(last_x0), 64'(-32'sd8388608));
    check("last_y0", 64'(last_y0), 64'd0);
    check("f1_idle", 64'(busy_o), 64'd0);

    // backpressure at pixel (1,0)
    push_frame(3, 1, 16'd7);
    s0 = start_cnt; d0 = done_cnt;
    start_frame(3, 1, 16'd100);
    wait_starts(s0 + 2, 60);
    pix_ready_i = 1'b0;
    for (int i = 0; i < 50 && !pix_valid_o; i++) tick();
    check("stall_valid", 64'(pix_valid_o), 64'd1);
    snap = {pix_col_o, pix_row_o, pix_eol_o, pix_last_o, pix_iter_o};
    check("stall_col", 64'(pix_col_o), 64'd1);
    stalling = 1; stall_bad = 0; stall_starts = 0;
    repeat (20) begin
      tick();
      if (!pix_valid_o || {pix_col_o, pix_row_o, pix_eol_o, pix_last_o, pix_iter_o} != snap) stall_bad++;
    end
    stalling = 0;
    check("stall_hold", 64'(stall_bad), 64'd0);
    check("stall_no_start", 64'(stall_starts), 64'd0);
    pix_ready_i = 1'b1;
    wait_done(d0, 200);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // empty frame
    s0 = start_cnt; d0 = done_cnt; busy_seen = 0;
    start_frame(0, 5, 16'd100);
    @(negedge clk_i);
    check("empty_done", 64'(frame_done_o), 64'd1);
    repeat (20) begin
      tick();
      if (busy_o) busy_seen++;
    end
    check("empty_busy", 64'(busy_seen), 64'd0);
    check("empty_no_start", 64'(start_cnt - s0), 64'd0);
    check("empty_done_pulses", 64'(done_cnt - d0), 64'd1);

    // reset mid-frame at pixel 5
    push_frame(4, 3, 16'd7);
    s0 = start_cnt;
    start_frame(4, 3, 16'd100);
    wait_starts(s0 + 6, 200);
    repeat (3) tick();
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_ctrl", 64'({core_start_o, pix_valid_o, busy_o, frame_done_o, pix_eol_o, pix_last_o}), 64'd0);
    check("mid_rst_core_xy", {core_x0_o, core_y0_o}, 64'd0);
    check("mid_rst_pix", 64'({pix_iter_o, pix_col_o, pix_row_o}), 64'd0);
    check("mid_rst_state", 64'(state_o), 64'd0);
    exp_q.delete();
    exp_coord_q.delete();
    d0 = done_cnt;
    repeat (3) tick();
    rst_i = 1'b0;
    repeat (3) tick();
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    push_frame(2, 2, 16'd7);
    d0 = done_cnt;
    start_frame(2, 2, 16'd100);
    wait_done(d0, 200);
    check("restart_queue_empty", 64'(exp_q.size() + exp_coord_q.size()), 64'd0);

    // inside counter
    exp_max_iter = 16'd50;
    res_q.push_back(16'd50);
    res_q.push_back(16'd3);
    exp_q.push_back({12'd0, 12'd0, 1'b0, 1'b0, 16'd50});
    exp_q.push_back({12'd1, 12'd0, 1'b1, 1'b1, 16'd3});
    exp_coord_q.push_back({XMIN, YMAX});
    exp_coord_q.push_back({XMIN + STEP, YMAX});
    d0 = done_cnt;
    start_frame(2, 1, 16'd50);
    wait_done(d0, 200);
    repeat (3) tick();
`ifdef MANDEL_SCHED_INSIDE_CNT_EN
    check("inside_count", 64'(inside_count_o), 64'd1);
`else
    check("inside_count", 64'(inside_count_o), 64'd0);
`endif
    check("inside_queue_empty", 64'(exp_q.size()), 64'd0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
